// File: rtl/fetch_pkg.sv
// Shared defaults and the queue entry layout for the instruction fetch queue.
package fetch_pkg;

  localparam int unsigned DEF_D     = 12;
  localparam int unsigned DEF_IW    = 9;
  localparam int unsigned DEF_DEPTH = 4;

  typedef struct packed {
    logic [DEF_D-1:0]  pc;
    logic [DEF_IW-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// ROM, redirect and decoder-facing signals of the fetch queue.
interface fetch_queue_if #(
  parameter int unsigned D     = fetch_pkg::DEF_D,
  parameter int unsigned IW    = fetch_pkg::DEF_IW,
  parameter int unsigned DEPTH = fetch_pkg::DEF_DEPTH
) ();
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [D-1:0]  rom_addr;
  logic [IW-1:0] rom_data;
  logic          redirect;
  logic [D-1:0]  redirect_pc;
  logic          stall;
  logic          instr_valid;
  logic [IW-1:0] instr;
  logic [D-1:0]  instr_pc;
  logic          instr_ready;
  logic          full;
  logic [CW-1:0] count;

  modport master (
    output rom_addr, instr_valid, instr, instr_pc, full, count,
    input  rom_data, redirect, redirect_pc, stall, instr_ready
  );

  modport slave (
    input  rom_addr, instr_valid, instr, instr_pc, full, count,
    output rom_data, redirect, redirect_pc, stall, instr_ready
  );
endinterface

// File: rtl/fetch_buf.sv
// Circular FIFO: synchronous write, asynchronous read of the head, flush clears pointers.
module fetch_buf #(
  parameter int unsigned W     = 21,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 wdata,
  output logic [W-1:0]                 rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] cnt;

  // Storage is not reset; validity is tracked by cnt alone.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign rdata = mem[head];
  assign count = cnt;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: owns the fetch PC and arbitrates push, pop and redirect.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned D     = DEF_D,
  parameter int unsigned IW    = DEF_IW,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.master bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [D-1:0]  pc;
    logic [IW-1:0] instr;
  } entry_t;

  logic [D-1:0]  fetch_pc;
  logic [CW-1:0] cnt;
  logic          full;
  logic          valid;
  logic          push;
  logic          pop;
  entry_t        wr_entry;
  entry_t        rd_entry;

  assign valid = (cnt != '0);
  assign full  = (cnt == CW'(DEPTH));

  // Redirect wins over everything; a full queue still accepts a push when it pops.
  assign pop  = !bus.redirect && valid && bus.instr_ready;
  assign push = !bus.redirect && !bus.stall && (!full || pop);

  assign wr_entry = '{pc: fetch_pc, instr: bus.rom_data};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= '0;
    end else if (bus.redirect) begin
      fetch_pc <= bus.redirect_pc;
    end else if (push) begin
      fetch_pc <= fetch_pc + D'(1);
    end
  end

  fetch_buf #(
    .W     (D + IW),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk   (clk),
    .reset (reset),
    .flush (bus.redirect),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .count (cnt)
  );

  assign bus.rom_addr    = fetch_pc;
  assign bus.instr_valid = valid;
  assign bus.instr       = rd_entry.instr;
  assign bus.instr_pc    = rd_entry.pc;
  assign bus.full        = full;
  assign bus.count       = cnt;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed table, corner sequences and random traffic vs a queue model.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int unsigned D     = 12;
  localparam int unsigned IW    = 9;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  logic redirect;
  logic [D-1:0] rpc;
  logic stall;
  logic ready;

  int total = 0;
  int bad   = 0;

  fetch_entry_t  mq[$];
  logic [D-1:0]  mpc;

  fetch_queue_if #(.D(D), .IW(IW), .DEPTH(DEPTH)) fq ();

  fetch_queue #(.D(D), .IW(IW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (fq.master)
  );

  always #5 clk = ~clk;

  // ROM contents: word at address i is i+1.
  assign fq.rom_data    = IW'(fq.rom_addr + 12'd1);
  assign fq.redirect    = redirect;
  assign fq.redirect_pc = rpc;
  assign fq.stall       = stall;
  assign fq.instr_ready = ready;

  typedef struct {
    logic        redirect;
    logic [11:0] rpc;
    logic        stall;
    logic        ready;
    int          exp_count;
    logic [11:0] exp_pc;
    logic [11:0] exp_addr;
  } vec_t;

  vec_t tbl[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit pop, push;
    if (redirect) begin
      mq.delete();
      mpc = rpc;
    end else begin
      pop  = (mq.size() > 0) && ready;
      push = !stall && ((mq.size() < DEPTH) || pop);
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back('{pc: mpc, instr: IW'(mpc + 12'd1)});
        mpc = mpc + 12'd1;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_check(input string tag);
    check({tag, ".count"}, 32'(fq.count), 32'(mq.size()));
    check({tag, ".valid"}, 32'(fq.instr_valid), 32'(mq.size() != 0));
    check({tag, ".full"},  32'(fq.full), 32'(mq.size() == DEPTH));
    check({tag, ".addr"},  32'(fq.rom_addr), 32'(mpc));
    if (mq.size() != 0) begin
      check({tag, ".ipc"},   32'(fq.instr_pc), 32'(mq[0].pc));
      check({tag, ".instr"}, 32'(fq.instr), 32'(mq[0].instr));
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    mq.delete();
    mpc = '0;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; redirect = 1'b0; rpc = '0; stall = 1'b0; ready = 1'b0;
    mq.delete(); mpc = '0;

    //                 redir rpc     stall rdy cnt pc      addr
    tbl[0]  = '{1'b0, 12'h000, 1'b0, 1'b0, 1, 12'h000, 12'h001};
    tbl[1]  = '{1'b0, 12'h000, 1'b0, 1'b0, 2, 12'h000, 12'h002};
    tbl[2]  = '{1'b0, 12'h000, 1'b0, 1'b0, 3, 12'h000, 12'h003};
    tbl[3]  = '{1'b0, 12'h000, 1'b0, 1'b0, 4, 12'h000, 12'h004};
    tbl[4]  = '{1'b0, 12'h000, 1'b0, 1'b0, 4, 12'h000, 12'h004};
    tbl[5]  = '{1'b0, 12'h000, 1'b0, 1'b1, 4, 12'h001, 12'h005};
    tbl[6]  = '{1'b0, 12'h000, 1'b0, 1'b1, 4, 12'h002, 12'h006};
    tbl[7]  = '{1'b0, 12'h000, 1'b0, 1'b1, 4, 12'h003, 12'h007};
    tbl[8]  = '{1'b0, 12'h000, 1'b0, 1'b1, 4, 12'h004, 12'h008};
    tbl[9]  = '{1'b0, 12'h000, 1'b0, 1'b1, 4, 12'h005, 12'h009};
    tbl[10] = '{1'b0, 12'h000, 1'b1, 1'b1, 3, 12'h006, 12'h009};
    tbl[11] = '{1'b0, 12'h000, 1'b1, 1'b1, 2, 12'h007, 12'h009};
    tbl[12] = '{1'b0, 12'h000, 1'b1, 1'b1, 1, 12'h008, 12'h009};
    tbl[13] = '{1'b0, 12'h000, 1'b1, 1'b1, 0, 12'h000, 12'h009};
    tbl[14] = '{1'b1, 12'hFFE, 1'b0, 1'b0, 0, 12'h000, 12'hFFE};
    tbl[15] = '{1'b0, 12'h000, 1'b0, 1'b1, 1, 12'hFFE, 12'hFFF};
    tbl[16] = '{1'b0, 12'h000, 1'b0, 1'b1, 1, 12'hFFF, 12'h000};
    tbl[17] = '{1'b0, 12'h000, 1'b0, 1'b1, 1, 12'h000, 12'h001};

    // Held in reset across edges
    @(posedge clk); @(posedge clk); #1;
    check("rst.count", 32'(fq.count), 32'd0);
    check("rst.valid", 32'(fq.instr_valid), 32'd0);
    check("rst.full",  32'(fq.full), 32'd0);
    check("rst.addr",  32'(fq.rom_addr), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 18; i++) begin
      redirect = tbl[i].redirect;
      rpc      = tbl[i].rpc;
      stall    = tbl[i].stall;
      ready    = tbl[i].ready;
      tick();
      check($sformatf("vec%0d.count", i), 32'(fq.count), 32'(tbl[i].exp_count));
      check($sformatf("vec%0d.valid", i), 32'(fq.instr_valid), 32'(tbl[i].exp_count != 0));
      check($sformatf("vec%0d.full", i),  32'(fq.full), 32'(tbl[i].exp_count == DEPTH));
      check($sformatf("vec%0d.addr", i),  32'(fq.rom_addr), 32'(tbl[i].exp_addr));
      if (tbl[i].exp_count != 0) begin
        check($sformatf("vec%0d.ipc", i),   32'(fq.instr_pc), 32'(tbl[i].exp_pc));
        check($sformatf("vec%0d.instr", i), 32'(fq.instr), 32'(IW'(tbl[i].exp_pc + 12'd1)));
      end
    end
    redirect = 1'b0; stall = 1'b0; ready = 1'b0;

    // Redirect with pc 3..6 queued and the decoder ready
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("rd.pre_ipc",   32'(fq.instr_pc), 32'h003);
    check("rd.pre_count", 32'(fq.count), 32'd4);
    redirect = 1'b1; rpc = 12'h040;
    tick();
    check("rd.count", 32'(fq.count), 32'd0);
    check("rd.addr",  32'(fq.rom_addr), 32'h040);
    redirect = 1'b0;
    tick();
    check("rd.valid", 32'(fq.instr_valid), 32'd1);
    check("rd.ipc",   32'(fq.instr_pc), 32'h040);
    model_check("rd");

    // Asynchronous reset mid-operation with three entries
    ready = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) tick();
    check("ar.pre_count", 32'(fq.count), 32'd3);
    reset = 1'b0;
    mq.delete();
    mpc = '0;
    #1;
    check("ar.count", 32'(fq.count), 32'd0);
    check("ar.valid", 32'(fq.instr_valid), 32'd0);
    check("ar.addr",  32'(fq.rom_addr), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Random traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      redirect = ($urandom_range(0, 15) == 0);
      rpc      = ($urandom_range(0, 1) == 0) ? 12'(12'hFFC + $urandom_range(0, 3))
                                             : 12'($urandom);
      stall    = ($urandom_range(0, 3) == 0);
      ready    = ($urandom_range(0, 1) == 1);
      tick();
      model_check($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
